// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//
// Multi-cycle ripple adder/subtractor.
// Operands are WIDTH bits wide. The adder handles CHUNK bits per clock. The
// carry between chunks is held in a register. It is the shared arithmetic unit
// of the multi-cycle datapath (ADD/ADDU/SUB/SUBU, address calculation), where
// a small adder matters more than single-cycle latency.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of CHUNK
//   CHUNK      bits added per clock (NCH = WIDTH/CHUNK clocks per operation)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; accepted on an edge where start && ready
//   sub        0: a + b + carry_in, 1: a - b (carry_in ignored)
//   carry_in   carry into bit 0, add mode only
//   a, b       operands, sampled at the accept edge
//   ready      high in IDLE only
//   done       one-cycle pulse: sum and flags are valid
//   sum        result, held until the next accept
//   carry_out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
//   zero       sum == 0
// -----------------------------------------------------------------------------
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b_eff;      // b, or ~b in subtract mode
    logic              r_carry;      // carry between chunks
    logic [IDXW-1:0]   r_idx;        // chunk being added this cycle
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry_out;
    logic              r_overflow;
    logic              r_zero;

    logic              w_accept;
    logic              w_last;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_chunk_res;
    logic              w_msb_cin;
    logic [WIDTH-1:0]  w_sum_next;

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    // One CHUNK-bit slice of the ripple adder. The operands are zero-extended
    // so that the top bit of the result is the carry out of the chunk.
    assign w_a_chunk   = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk   = r_b_eff[r_idx*CHUNK +: CHUNK];
    assign w_chunk_res = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

    // Carry into the MSB, recovered from its sum bit: s = a ^ b ^ cin.
    // This is only meaningful on the last chunk, where it feeds the overflow flag.
    assign w_msb_cin = w_chunk_res[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];

    // The result with the current chunk merged in. The zero flag is taken from
    // this value on the last chunk, so that the flag does not lag one cycle.
    always_comb begin
        // NOTE: assign every combinational output a default first, so that no path leaves it unassigned and infers a latch.
        w_sum_next = r_sum;
        w_sum_next[r_idx*CHUNK +: CHUNK] = w_chunk_res[CHUNK-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking (<=), so that every flop samples pre-edge values regardless of block order.
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)   w_state_next = ST_DONE;
            ST_DONE:               w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register is reset, operands included, so nothing downstream can ever see X.
            r_a         <= '0;
            r_b_eff     <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1. The +1 enters as the initial carry.
            r_a         <= a;
            r_b_eff     <= sub ? ~b : b;
            r_carry     <= sub ? 1'b1 : carry_in;
            r_idx       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_chunk_res[CHUNK];
            if (w_last) begin
                r_carry_out <= w_chunk_res[CHUNK];
                r_overflow  <= w_msb_cin ^ w_chunk_res[CHUNK];
                r_zero      <= (w_sum_next == '0);
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
//
// Directed test of multicycle_adder. It uses three instances:
//   dut32  WIDTH=32 CHUNK=8  directed vectors with hand-computed results
//   dut_c1 WIDTH=4  CHUNK=1  exhaustive a, b, carry_in, sub; start held high
//   dut_c4 WIDTH=4  CHUNK=4  same sweep, single-cycle RUN
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 32-bit instance
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        carry_in = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready;
    logic        done;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    // 4-bit instances (shared operands, separate start)
    logic        start_c1 = 1'b0;
    logic        start_c4 = 1'b0;
    logic        sub4 = 1'b0;
    logic        ci4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        ready_c1, done_c1, co_c1, ov_c1, z_c1;
    logic [3:0]  sum_c1;
    logic        ready_c4, done_c4, co_c4, ov_c4, z_c4;
    logic [3:0]  sum_c4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .carry_in(carry_in),
        .a(a), .b(b), .ready(ready), .done(done), .sum(sum),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    multicycle_adder #(.WIDTH(4), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_c1), .sub(sub4), .carry_in(ci4),
        .a(a4), .b(b4), .ready(ready_c1), .done(done_c1), .sum(sum_c1),
        .carry_out(co_c1), .overflow(ov_c1), .zero(z_c1)
    );

    multicycle_adder #(.WIDTH(4), .CHUNK(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .start(start_c4), .sub(sub4), .carry_in(ci4),
        .a(a4), .b(b4), .ready(ready_c4), .done(done_c4), .sum(sum_c4),
        .carry_out(co_c4), .overflow(ov_c4), .zero(z_c4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // 4-bit reference: {carry_out, overflow, zero, sum}. Overflow uses the
    // sign-bit rule (equal operand signs, different result sign).
    function automatic logic [6:0] model4(input logic [3:0] av, input logic [3:0] bv,
                                          input logic ci, input logic sb);
        logic [3:0] be;
        logic [4:0] t;
        logic       ov;
        be = sb ? ~bv : bv;
        t  = {1'b0, av} + {1'b0, be} + {4'b0, (sb ? 1'b1 : ci)};
        ov = (av[3] == be[3]) && (t[3] != av[3]);
        return {t[4], ov, (t[3:0] == 4'h0), t[3:0]};
    endfunction

    // Runs one 32-bit operation. It is entered and left just after a falling edge.
    task automatic op32(input string tag, input logic sb, input logic ci,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_sum, input logic exp_co,
                        input logic exp_ov, input logic exp_z);
        int lat;
        check({tag, "_ready"}, 32'(ready), 32'd1);
        start = 1'b1; sub = sb; carry_in = ci; a = av; b = bv;
        @(posedge clk);                        // accept edge
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;        // later operand changes must be ignored
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_flags"}, {29'b0, carry_out, overflow, zero}, {29'b0, exp_co, exp_ov, exp_z});
        @(negedge clk);
        check({tag, "_back_idle"}, {30'b0, ready, done}, 32'b10);
    endtask

    // Exhaustive 4-bit sweep on one instance, with start held high.
    task automatic exh(input string tag, input bit which, input int exp_lat);
        int lat;
        logic [10:0] v;
        logic [6:0]  obs;
        logic        dn;
        for (int i = 0; i < 1024; i++) begin
            v = 11'(i);
            @(negedge clk);                    // DONE -> IDLE edge has passed
            {sub4, ci4, a4, b4} = v[9:0];
            if (which) start_c4 = 1'b1; else start_c1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat = 0;
            dn  = which ? done_c4 : done_c1;
            while (!dn && lat < 10) begin
                @(negedge clk);
                lat++;
                dn = which ? done_c4 : done_c1;
            end
            obs = which ? {co_c4, ov_c4, z_c4, sum_c4} : {co_c1, ov_c1, z_c1, sum_c1};
            check($sformatf("%s_op%0d", tag, i), {21'b0, lat[3:0], obs},
                  {21'b0, 4'(exp_lat), model4(v[7:4], v[3:0], v[8], v[9])});
        end
        start_c1 = 1'b0;
        start_c4 = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         n_done;
        logic [31:0] cap;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'b0, ready, done, carry_out, overflow, zero, 2'b0}, 32'b1000000);
        check("reset_sum", sum, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);

        // Directed arithmetic vectors
        op32("add_wrap",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        op32("add_ovf",    1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        op32("sub_neg",    1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        op32("sub_ovf",    1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        op32("add_cin",    1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        op32("sub_cin_ig", 1'b1, 1'b1, 32'h0000_000A, 32'h0000_000A, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // A start while RUN is ignored: one done pulse, first result kept
        start = 1'b1; sub = 1'b0; carry_in = 1'b0; a = 32'h0000_0100; b = 32'h0000_0200;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; sub = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0000_0001;
        n_done = 0;
        cap = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (done) begin
                n_done++;
                cap = sum;
            end
        end
        check("busy_start_done_count", 32'(n_done), 32'd1);
        check("busy_start_result", cap, 32'h0000_0300);
        check("busy_start_sum_held", sum, 32'h0000_0300);
        check("busy_start_ready", 32'(ready), 32'd1);

        // Reset two cycles into an operation
        sub = 1'b0; start = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {27'b0, done, carry_out, overflow, zero, 1'b0}, 32'h0);
        check("midreset_sum", sum, 32'h0);
        n_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        #1;
        check("midreset_ready", 32'(ready), 32'd1);
        repeat (5) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midreset_no_done", 32'(n_done), 32'd0);
        check("midreset_sum_after", sum, 32'h0);
        op32("after_reset", 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 1'b0, 1'b0);

        // Exhaustive 4-bit sweeps
        exh("w4c1", 1'b0, 4);
        exh("w4c4", 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
